mult8_dot_accumulator: RTL and testbench

- Sequential stage directly downstream of the team's combinational 8x8 unsigned multiplier core.
- Accepts streamed operand pairs over a valid/ready handshake and registers them into the core.
- Registers the 16-bit product, then accumulates products into a dot-product sum per vector.
- A vector is delimited by in_last; one result is emitted per vector over a valid/ready handshake.

---
 rtl/mult8_dot_pkg.sv | 18 +
 rtl/mult8_dot_accumulator_if.sv | 34 +++
 rtl/mult8_core.sv | 12 +
 rtl/mult8_dot_acc.sv | 89 ++++++++
 rtl/mult8_dot_accumulator.sv | 98 +++++++++
 tb/tb_mult8_dot_accumulator.sv | 387 ++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mult8_dot_pkg.sv
// Shared constants and types for the 8x8 dot-product accumulator.
package mult8_dot_pkg;

    // Default accumulator/result width and element-count width.
    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CNT_W_DEF = 8;

    // Operand and product widths of the multiplier core.
    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;

    // S3 accumulator FSM states.
    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/mult8_dot_accumulator_if.sv
// Streaming bus for the dot-product accumulator: an operand-pair input stream and a
// result output stream, each with a valid/ready handshake.
interface mult8_dot_accumulator_if
    import mult8_dot_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    // The accumulator block.
    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/mult8_core.sv
// Combinational 8x8 unsigned multiplier core.
module mult8_core
    import mult8_dot_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mult8_dot_acc.sv
// S3 of the dot-product pipeline: accumulator FSM with saturating element count,
// sticky overflow flag and the registered result outputs.
// Build option: MULT8_DOT_SAT_EN clamps the sum at 2^ACC_W-1 on overflow; without it
// the sum wraps modulo 2^ACC_W. Overflow is reported in both builds.
module mult8_dot_acc
    import mult8_dot_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              v2,
    input  logic              last2,
    input  logic [PROD_W-1:0] p,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam int unsigned    SUM_W   = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    acc_state_t       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic [SUM_W-1:0] sum_wide;
    logic [ACC_W-1:0] acc_new;
    logic [CNT_W-1:0] cnt_new;
    logic             ovf_new;

    // Next accumulator value, count and overflow for the product arriving from S2.
    always_comb begin
        sum_wide = {1'b0, acc_q} + SUM_W'(p);
        acc_new  = ACC_W'(p);
        cnt_new  = CNT_W'(1);
        ovf_new  = 1'b0;
        if (state_q == ACC_RUN) begin
            // Carry out of the ACC_W-bit sum is the overflow event.
            ovf_new = ovf_q | sum_wide[ACC_W];
            cnt_new = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef MULT8_DOT_SAT_EN
            // Once overflowed, stay pinned at the maximum for the rest of the vector.
            acc_new = ovf_new ? ACC_MAX : sum_wide[ACC_W-1:0];
`else
            acc_new = sum_wide[ACC_W-1:0];
`endif
        end
    end

    // FSM state, accumulator and registered result; everything freezes while en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            if (v2) begin
                acc_q <= acc_new;
                cnt_q <= cnt_new;
                ovf_q <= ovf_new;
                if (last2) begin
                    state_q   <= ACC_IDLE;
                    out_valid <= 1'b1;
                    out_sum   <= acc_new;
                    out_count <= cnt_new;
                    out_ovf   <= ovf_new;
                end else begin
                    state_q   <= ACC_RUN;
                    out_valid <= 1'b0;
                end
            end else begin
                // en with a pending result means it was just consumed.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult8_dot_accumulator.sv
// Dot-product accumulator downstream of the 8x8 multiplier core.
// S1 registers the operand pair, S2 registers the product, S3 (mult8_dot_acc)
// accumulates per vector and holds the result until the consumer takes it.
// A single enable stalls all three stages while a result is waiting.
// Build option: MULT8_DOT_SAT_EN selects saturating instead of wrapping accumulation.
module mult8_dot_accumulator
    import mult8_dot_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mult8_dot_accumulator_if.slave bus
);

    logic              en;

    logic              v1_q;
    logic [OP_W-1:0]   a1_q;
    logic [OP_W-1:0]   b1_q;
    logic              last1_q;

    logic [PROD_W-1:0] prod;

    logic              v2_q;
    logic [PROD_W-1:0] p2_q;
    logic              last2_q;

    logic              res_valid;
    logic [ACC_W-1:0]  res_sum;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;

    // The pipeline moves whenever no result is stuck at the output.
    assign en           = !res_valid || bus.out_ready;
    assign bus.in_ready = en;

    assign bus.out_valid = res_valid;
    assign bus.out_sum   = res_sum;
    assign bus.out_count = res_count;
    assign bus.out_ovf   = res_ovf;

    // S1: capture the operand pair on a transfer; data only loads when valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            last1_q <= 1'b0;
        end else if (en) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                a1_q    <= bus.in_a;
                b1_q    <= bus.in_b;
                last1_q <= bus.in_last;
            end
        end
    end

    mult8_core u_core (
        .a (a1_q),
        .b (b1_q),
        .p (prod)
    );

    // S2: register the product alongside its valid and end-of-vector marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            p2_q    <= '0;
            last2_q <= 1'b0;
        end else if (en) begin
            v2_q <= v1_q;
            if (v1_q) begin
                p2_q    <= prod;
                last2_q <= last1_q;
            end
        end
    end

    mult8_dot_acc #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .v2        (v2_q),
        .last2     (last2_q),
        .p         (p2_q),
        .out_valid (res_valid),
        .out_sum   (res_sum),
        .out_count (res_count),
        .out_ovf   (res_ovf)
    );

endmodule

// File: tb/tb_mult8_dot_accumulator.sv
// Self-checking bench for mult8_dot_accumulator: directed scenarios plus a randomized
// stream checked against a per-vector arithmetic reference model.
module tb_mult8_dot_accumulator;

    localparam int unsigned ACC_W = 24;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mult8_dot_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mult8_dot_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: result of a vector from its exact product total and element count.
    function automatic res_t model(input longint total, input int n);
        res_t   r;
        longint lim;
        lim = longint'(1) << ACC_W;
        r.ovf = (total >= lim);
`ifdef MULT8_DOT_SAT_EN
        r.sum = r.ovf ? ACC_W'(lim - 1) : ACC_W'(total);
`else
        r.sum = ACC_W'(total % lim);
`endif
        r.count = (n >= (1 << CNT_W)) ? {CNT_W{1'b1}} : CNT_W'(n);
        return r;
    endfunction

    // Present one pair and hold it until accepted; returns just after the accepting edge.
    task automatic drive_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        int w;
        w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        #1;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL drive_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid);
        end
        n_tests++;
        if (bus.out_sum !== '0) begin
            n_fail++; $display("FAIL reset_out_sum: got %0h required 0", bus.out_sum);
        end
        n_tests++;
        if (bus.out_count !== '0) begin
            n_fail++; $display("FAIL reset_out_count: got %0d required 0", bus.out_count);
        end
        n_tests++;
        if (bus.out_ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_ovf: got %0b required 0", bus.out_ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        drive_pair(8'd255, 8'd255, 1'b1);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_early1: out_valid=%0b required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_early2: out_valid=%0b required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_valid: out_valid=%0b required 1", bus.out_valid);
        end
        n_tests++;
        if (bus.out_sum !== 24'hFE01 || bus.out_count !== 8'd1 || bus.out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: sum=%0h count=%0d ovf=%0b required fe01 1 0",
                     bus.out_sum, bus.out_count, bus.out_ovf);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_clear: out_valid=%0b required 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int               pulses;
        logic [ACC_W-1:0] s;
        logic [CNT_W-1:0] c;
        pulses = 0; s = '0; c = '0;
        bus.out_ready = 1'b1;
        drive_pair(8'd1, 8'd2, 1'b0);
        drive_pair(8'd3, 8'd4, 1'b0);
        drive_pair(8'd5, 8'd6, 1'b0);
        drive_pair(8'd7, 8'd8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                pulses++; s = bus.out_sum; c = bus.out_count;
            end
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL b2b_pulses: got %0d required 1", pulses);
        end
        n_tests++;
        if (s !== 24'd100 || c !== 8'd4) begin
            n_fail++; $display("FAIL b2b_result: sum=%0d count=%0d required 100 4", s, c);
        end
    endtask

    task automatic test_backpressure();
        int               pulses;
        logic [ACC_W-1:0] s;
        logic [CNT_W-1:0] c;
        pulses = 0; s = '0; c = '0;
        bus.out_ready = 1'b0;
        drive_pair(8'd2, 8'd3, 1'b1);
        drive_pair(8'd4, 8'd5, 1'b0);
        drive_pair(8'd6, 8'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 24'd6 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%0b sum=%0d in_ready=%0b required 1 6 0",
                         i, bus.out_valid, bus.out_sum, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                pulses++; s = bus.out_sum; c = bus.out_count;
            end
        end
        n_tests++;
        if (pulses !== 1 || s !== 24'd62 || c !== 8'd2) begin
            n_fail++;
            $display("FAIL bp_release: pulses=%0d sum=%0d count=%0d required 1 62 2",
                     pulses, s, c);
        end
    endtask

    task automatic test_overflow();
        int               w;
        logic [ACC_W-1:0] exp_sum;
        w = 0;
`ifdef MULT8_DOT_SAT_EN
        exp_sum = 24'hFFFFFF;
`else
        exp_sum = 24'd64259;
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 259; i++) drive_pair(8'd255, 8'd255, (i == 258));
        while (!bus.out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovf_valid: got %0b required 1", bus.out_valid);
        end
        n_tests++;
        if (bus.out_sum !== exp_sum || bus.out_count !== 8'd255 || bus.out_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_result: sum=%0h count=%0d ovf=%0b required %0h 255 1",
                     bus.out_sum, bus.out_count, bus.out_ovf, exp_sum);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int               pulses;
        logic [ACC_W-1:0] s;
        logic [CNT_W-1:0] c;
        pulses = 0; s = '0; c = '0;
        bus.out_ready = 1'b1;
        drive_pair(8'd3, 8'd4, 1'b0);
        drive_pair(8'd5, 8'd6, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_valid: got %0b required 0", bus.out_valid);
        end
        drive_pair(8'd10, 8'd10, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                pulses++; s = bus.out_sum; c = bus.out_count;
            end
        end
        n_tests++;
        if (pulses !== 1 || s !== 24'd100 || c !== 8'd1) begin
            n_fail++;
            $display("FAIL rstmid_result: pulses=%0d sum=%0d count=%0d required 1 100 1",
                     pulses, s, c);
        end
    endtask

    task automatic test_random();
        res_t exp_q[$];
        bit   drv_done;
        int   n_res;
        drv_done = 1'b0;
        n_res = 0;
        fork
            begin : driver
                int  sent;
                bit  abort;
                sent = 0;
                abort = 1'b0;
                while (sent < 10000 && !abort) begin
                    int        n;
                    bit        big;
                    longint    total;
                    logic [7:0] av[$];
                    logic [7:0] bv[$];
                    big = ($urandom_range(0, 39) == 0);
                    n = big ? $urandom_range(250, 300) : $urandom_range(1, 8);
                    total = 0;
                    for (int i = 0; i < n; i++) begin
                        logic [7:0] a;
                        logic [7:0] b;
                        a = big ? 8'($urandom_range(200, 255)) : 8'($urandom);
                        b = big ? 8'($urandom_range(200, 255)) : 8'($urandom);
                        av.push_back(a);
                        bv.push_back(b);
                        total += longint'(a) * longint'(b);
                    end
                    exp_q.push_back(model(total, n));
                    for (int i = 0; i < n && !abort; i++) begin
                        bit fire;
                        int tries;
                        fire = 1'b0;
                        tries = 0;
                        while (!fire && tries < 200) begin
                            @(negedge clk);
                            #1;
                            if ($urandom_range(0, 3) != 0) begin
                                bus.in_valid = 1'b1;
                                bus.in_a     = av[i];
                                bus.in_b     = bv[i];
                                bus.in_last  = (i == n - 1);
                            end else begin
                                bus.in_valid = 1'b0;
                                bus.in_a     = 8'($urandom);
                                bus.in_b     = 8'($urandom);
                                bus.in_last  = 1'($urandom);
                            end
                            #1;
                            fire = bus.in_valid && bus.in_ready;
                            tries++;
                        end
                        if (!fire) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL rand_stall: pair %0d not accepted", sent);
                            abort = 1'b1;
                        end
                        sent++;
                    end
                end
                @(negedge clk);
                #1 bus.in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin : monitor
                int               cyc;
                bit               held;
                logic [ACC_W-1:0] h_sum;
                logic [CNT_W-1:0] h_cnt;
                logic             h_ovf;
                cyc = 0;
                held = 1'b0;
                h_sum = '0; h_cnt = '0; h_ovf = 1'b0;
                while (!(drv_done && exp_q.size() == 0) && cyc < 60000) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                    #1;
                    cyc++;
                    if (held) begin
                        n_tests++;
                        if (bus.out_valid !== 1'b1 || bus.out_sum !== h_sum ||
                            bus.out_count !== h_cnt || bus.out_ovf !== h_ovf) begin
                            n_fail++;
                            $display("FAIL rand_hold: valid=%0b sum=%0h count=%0d ovf=%0b required 1 %0h %0d %0b",
                                     bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf,
                                     h_sum, h_cnt, h_ovf);
                        end
                    end
                    held  = bus.out_valid && !bus.out_ready;
                    h_sum = bus.out_sum;
                    h_cnt = bus.out_count;
                    h_ovf = bus.out_ovf;
                    if (bus.out_valid && bus.out_ready) begin
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL rand_extra: sum=%0h count=%0d required no result",
                                     bus.out_sum, bus.out_count);
                        end else begin
                            res_t e;
                            e = exp_q.pop_front();
                            if (bus.out_sum !== e.sum || bus.out_count !== e.count ||
                                bus.out_ovf !== e.ovf) begin
                                n_fail++;
                                $display("FAIL rand_result[%0d]: sum=%0h count=%0d ovf=%0b required %0h %0d %0b",
                                         n_res, bus.out_sum, bus.out_count, bus.out_ovf,
                                         e.sum, e.count, e.ovf);
                            end
                        end
                        n_res++;
                    end
                end
                n_tests++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL rand_missing: %0d results outstanding required 0",
                             exp_q.size());
                end
            end
        join
        bus.out_ready = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
